// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and widths for the reset sequencer
package reset_sequencer_pkg;

    // Width of the saturating watchdog trip counter exported to debug/OSD.
    localparam int TRIP_W = 8;

    // Sequencer states: all held, peripherals released, fully running.
    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_PERIPH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

endpackage

// File: rtl/reset_sequencer_sync2.sv
// rtl/reset_sequencer_sync2.sv - two-flop synchronizer for asynchronous cabinet inputs
module reset_sequencer_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both park at RESET_VAL so no false edge appears after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged cabinet reset release driven by system reset and watchdog trips
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int CNT_W          = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              wdresetn_in,
    output logic              cpu_reset_n,
    output logic              periph_reset_n,
    output logic              wd_clr_n,
    output logic              busy,
    output logic [TRIP_W-1:0] trip_count
);

    localparam logic [CNT_W-1:0]  HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [TRIP_W-1:0] TRIP_MAX     = '1;

    logic             wd_sync;
    logic             wd_prev;
    logic             trip_det;
    logic             trip_pend;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             trip_take;

    reset_sequencer_sync2 #(
        .RESET_VAL(1'b1)
    ) u_wd_sync (
        .clk  (clk),
        .reset(reset),
        .d    (wdresetn_in),
        .q    (wd_sync)
    );

    // Falling edge of the synchronized request; a stuck-low request trips only once.
    assign trip_det = wd_prev & ~wd_sync;

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_prev <= 1'b1;
        end else begin
            wd_prev <= wd_sync;
        end
    end

    // Hold a trip seen in RUN while ce=0 so it is acted on at the next enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trip_pend <= 1'b0;
        end else if (state == ST_RUN && !ce && trip_det) begin
            trip_pend <= 1'b1;
        end else if (state != ST_RUN || ce) begin
            trip_pend <= 1'b0;
        end
    end

    // Next-state and shared down-counter; nothing moves unless ce is high.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        trip_take = 1'b0;
        if (ce) begin
            case (state)
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = ST_PERIPH;
                        cnt_nxt   = STAGGER_LOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_PERIPH: begin
                    if (cnt == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (trip_det || trip_pend) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = HOLD_LOAD;
                        trip_take = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            endcase
        end
    end

    // State, counter and saturating trip count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HOLD;
            cnt        <= HOLD_LOAD;
            trip_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (trip_take && trip_count != TRIP_MAX) begin
                trip_count <= trip_count + TRIP_W'(1);
            end
        end
    end

    // Outputs registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            periph_reset_n <= 1'b0;
            cpu_reset_n    <= 1'b0;
            wd_clr_n       <= 1'b0;
            busy           <= 1'b1;
        end else begin
            periph_reset_n <= (state_nxt != ST_HOLD);
            cpu_reset_n    <= (state_nxt == ST_RUN);
            wd_clr_n       <= (state_nxt == ST_RUN);
            busy           <= (state_nxt != ST_RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       wdresetn_in;
    logic       cpu_reset_n;
    logic       periph_reset_n;
    logic       wd_clr_n;
    logic       busy;
    logic [7:0] trip_count;

    int errors = 0;
    int checks = 0;
    int exp_trips;

    reset_sequencer #(
        .HOLD_CYCLES   (8),
        .STAGGER_CYCLES(4),
        .CNT_W         (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ce            (ce),
        .wdresetn_in   (wdresetn_in),
        .cpu_reset_n   (cpu_reset_n),
        .periph_reset_n(periph_reset_n),
        .wd_clr_n      (wd_clr_n),
        .busy          (busy),
        .trip_count    (trip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_periph"}, periph_reset_n, 0);
        check({tag, "_cpu"}, cpu_reset_n, 0);
        check({tag, "_wdclr"}, wd_clr_n, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    // Step k=1..c_at edges from a sequence start, checking each edge's outputs.
    task automatic run_seq(input string tag, input int p_at, input int c_at,
                           input int drop_at, input bit toggle);
        for (int k = 1; k <= c_at; k++) begin
            if (toggle) ce = (k % 2 == 0);
            step();
            check({tag, "_periph"}, periph_reset_n, (k >= p_at));
            check({tag, "_cpu"}, cpu_reset_n, (k >= c_at));
            check({tag, "_wdclr"}, wd_clr_n, (k >= c_at));
            check({tag, "_busy"}, busy, (k < c_at));
            if (k == drop_at) wdresetn_in = 1'b0;
        end
        ce = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        ce          = 1'b1;
        wdresetn_in = 1'b1;

        // 1: power-on
        repeat (3) step();
        check_all_low("rst");
        check("rst_trip", trip_count, 0);
        reset = 1'b0;
        run_seq("por", 8, 12, 0, 1'b0);
        check("por_trip", trip_count, 0);

        // 2: watchdog trip in RUN, request held low afterwards
        wdresetn_in = 1'b0;
        step();
        step();
        check("trip_pre_cpu", cpu_reset_n, 1);
        step();
        check_all_low("trip");
        check("trip_cnt1", trip_count, 1);
        run_seq("replay", 8, 12, 0, 1'b0);
        repeat (10) step();
        check("stuck_busy", busy, 0);
        check("stuck_trip", trip_count, 1);
        wdresetn_in = 1'b1;
        repeat (3) step();

        // 3: trip during PERIPH is ignored
        wdresetn_in = 1'b0;
        repeat (3) step();
        check_all_low("trip2");
        check("trip_cnt2", trip_count, 2);
        wdresetn_in = 1'b1;
        run_seq("periph_trip", 8, 12, 8, 1'b0);
        check("periph_trip_cnt", trip_count, 2);
        wdresetn_in = 1'b1;
        repeat (5) step();
        check("periph_trip_run", busy, 0);

        // 5: saturation of the trip counter
        exp_trips = 2;
        for (int i = 0; i < 300; i++) begin
            wdresetn_in = 1'b0;
            repeat (3) step();
            wdresetn_in = 1'b1;
            repeat (12) step();
            if (exp_trips < 255) exp_trips++;
            check("sat_cnt", trip_count, exp_trips);
        end
        check("sat_final", trip_count, 255);
        check("sat_busy", busy, 0);

        // 6: reset asserted during HOLD after a trip
        wdresetn_in = 1'b0;
        repeat (3) step();
        wdresetn_in = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        #1;
        check_all_low("midrst");
        check("midrst_trip", trip_count, 0);
        repeat (2) step();
        reset = 1'b0;
        run_seq("restart", 8, 12, 0, 1'b0);
        check("restart_trip", trip_count, 0);

        // 4: ce toggling 0/1 from power-on
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        run_seq("ce_tog", 16, 24, 0, 1'b1);
        check("ce_tog_trip", trip_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
